key4_onehot_capture: RTL and testbench
======================================

// Module: key4_onehot_capture
// PURPOSE
//   Captures four raw push-button inputs and delivers a clean, registered one-hot
//   code to the downstream 4-to-2 encoder input a[3:0], plus a one-cycle valid strobe.
//   Each input passes through a 2-FF synchroniser and then a shared debounce FSM.
//   Presses of more than one key are rejected and flagged, never forwarded.
//   The block sits directly upstream of the encoder.
// PARAMETERS
//   DEB_CYCLES  16  consecutive stable cycles required for press and release; must be >= 2
//   CNT_W        5  debounce counter width; 2**CNT_W must be > DEB_CYCLES-1
// PORTS
//   clk        in   1  single system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   key_in     in   4  raw asynchronous buttons, 1 = pressed
//   onehot     out  4  last accepted one-hot code; drives encoder a[3:0]
//   key_valid  out  1  one-cycle pulse when onehot is updated
//   multi_err  out  1  one-cycle pulse when a debounced multi-key press is rejected
//   busy       out  1  high whenever the FSM is not in IDLE
// BEHAVIOUR
//   Reset: async assert clears sync regs, snap, cnt, onehot=0, key_valid=0, multi_err=0;
//     state=IDLE so busy=0. Reset mid-debounce aborts; no pulse is emitted.
//   Sync: key_s = 2nd sync stage; key_s follows key_in after 2 clock edges.
//   FSM states (registered, 2-bit): IDLE, DEBOUNCE, HOLD, RELEASE.
//   IDLE: key_s==0 -> stay. key_s!=0 -> DEBOUNCE, snap<=key_s, cnt<=0.
//   DEBOUNCE:
//     key_s==0 -> IDLE.
//     key_s!=snap (nonzero) -> snap<=key_s, cnt<=0, stay.
//     key_s==snap, cnt<DEB_CYCLES-1 -> cnt<=cnt+1.
//     key_s==snap, cnt==DEB_CYCLES-1 -> HOLD. If popcount(snap)==1, onehot<=snap and
//       key_valid<=1. Otherwise multi_err<=1 and onehot is unchanged.
//   HOLD: key_s!=0 -> stay (no repeat, no re-evaluation). key_s==0 -> RELEASE, cnt<=0.
//   RELEASE: key_s!=0 -> HOLD. Otherwise cnt<=cnt+1; at cnt==DEB_CYCLES-1 -> IDLE.
//   key_valid and multi_err are registered pulses lasting exactly 1 cycle; both are never
//     high in the same cycle.
//   onehot holds its value until the next accepted press. It is never 0 after the first
//     accept, and it is never multi-hot.
//   Latency: let edge 1 be the first edge that samples a stable press. key_valid is high
//     in the cycle after edge DEB_CYCLES+3, and onehot updates on that same edge.
//   Bounce during DEBOUNCE restarts the count. Bounce during RELEASE returns to HOLD
//     with no new pulse.
//   A second key added while in HOLD is ignored until all keys are released and the
//     release debounce completes.
//   busy = (state != IDLE), decoded combinationally from the state register.
// TESTING
//   DEB_CYCLES=4 throughout; key_in is driven away from clock edges.
//   1) Reset, then key_in=4'b0100 held -> key_valid pulses once, in the cycle after
//      edge 7; onehot=4'b0100; multi_err stays 0.
//   2) key_in=4'b0011 held for 20 cycles -> multi_err pulses once; onehot keeps its
//      prior value; key_valid stays 0.
//   3) Bounce: 4'b0001 for 2 cycles, then 0 for 1 cycle, then 4'b0001 held -> exactly
//      one key_valid pulse, after a full re-debounce; onehot=4'b0001.
//   4) Hold 4'b1000 for 50 cycles -> a single key_valid pulse; busy=1 until key_in=0
//      and 4 stable release cycles have elapsed; then busy=0.
//   5) Assert rst mid-DEBOUNCE with 4'b0010 pressed -> outputs go to 0 immediately, no
//      pulse is emitted; after deassert the press is re-debounced from IDLE.
//   6) Sequence 0001, 0010, 0100, 1000, each separated by a full release -> four pulses;
//      the downstream encoder yields y=0,1,2,3.

Source files
------------

// File: rtl/key4_onehot_capture.sv
// Synchronises and debounces four push-buttons into a registered one-hot code with a valid strobe.
// Latency: DEB_CYCLES+3 edges from the first sampled stable press. No backpressure; pulses are one cycle wide.
module key4_onehot_capture #(
   parameter int unsigned DEB_CYCLES = 16,
   parameter int unsigned CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_in,
   output logic [3:0] onehot,
   output logic       key_valid,
   output logic       multi_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   state_t           state;
   logic [3:0]       key_m;
   logic [3:0]       key_s;
   logic [3:0]       snap;
   logic [CNT_W-1:0] cnt;
   logic             snap_single;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_m <= 4'd0;
         key_s <= 4'd0;
      end else begin
         key_m <= key_in;
         key_s <= key_m;
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   assign snap_single = (snap != 4'd0) && ((snap & (snap - 4'd1)) == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         snap      <= 4'd0;
         cnt       <= '0;
         onehot    <= 4'd0;
         key_valid <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         multi_err <= 1'b0;
         case (state)
            IDLE: begin
               if (key_s != 4'd0) begin
                  state <= DEBOUNCE;
                  snap  <= key_s;
                  cnt   <= '0;
               end
            end
            DEBOUNCE: begin
               if (key_s == 4'd0) begin
                  state <= IDLE;
               end else if (key_s != snap) begin
                  snap <= key_s;
                  cnt  <= '0;
               end else if (cnt != CNT_LAST) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  state <= HOLD;
                  if (snap_single) begin
                     onehot    <= snap;
                     key_valid <= 1'b1;
                  end else begin
                     multi_err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               // Any change while keys stay down is ignored until a full release.
               if (key_s == 4'd0) begin
                  state <= RELEASE;
                  cnt   <= '0;
               end
            end
            RELEASE: begin
               if (key_s != 4'd0) begin
                  state <= HOLD;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_key4_onehot_capture.sv
// Scoreboard bench for key4_onehot_capture with DEB_CYCLES=4 and directed key patterns.
module tb_key4_onehot_capture;

   localparam int DEB = 4;
   localparam int LAT = DEB + 3;

   logic       clk;
   logic       rst;
   logic [3:0] key_in;
   logic [3:0] onehot;
   logic       key_valid;
   logic       multi_err;
   logic       busy;

   int checks;
   int errors;
   int cyc;

   typedef struct {
      bit         is_err;
      logic [3:0] oh;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   key4_onehot_capture #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .onehot    (onehot),
      .key_valid (key_valid),
      .multi_err (multi_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] enc(input logic [3:0] a);
      logic [1:0] y;
      y = 2'd0;
      if (a[1]) y = 2'd1;
      if (a[2]) y = 2'd2;
      if (a[3]) y = 2'd3;
      return y;
   endfunction

   task automatic expect_pulse(input bit is_err, input logic [3:0] oh, input int at_cyc);
      exp_t e;
      e.is_err = is_err;
      e.oh     = oh;
      e.cyc    = at_cyc;
      sb.push_back(e);
   endtask

   // Drops all keys and checks busy stays high through the release debounce, then falls.
   task automatic release_chk(input string tag);
      key_in = 4'd0;
      repeat (LAT - 1) @(negedge clk);
      check({tag, "_busy_in_release"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({tag, "_busy_after_release"}, {31'd0, busy}, 32'd0);
   endtask

   // Monitor: every output pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && (key_valid || multi_err)) begin
         exp_t e;
         check("pulse_exclusive", {31'd0, key_valid & multi_err}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, key_valid, multi_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_kind_err", {31'd0, multi_err}, {31'd0, e.is_err});
            check("pulse_onehot", {28'd0, onehot}, {28'd0, e.oh});
            check("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [3:0] seq [4];
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      key_in = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_onehot", {28'd0, onehot}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_multi_err", {31'd0, multi_err}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1) single key accepted after DEB+3 edges
      key_in = 4'b0100;
      expect_pulse(1'b0, 4'b0100, cyc + LAT);
      repeat (12) @(negedge clk);
      check("t1_onehot", {28'd0, onehot}, 32'h4);
      check("t1_busy_hold", {31'd0, busy}, 32'd1);
      release_chk("t1");

      // 2) two keys: rejected, onehot keeps 0100
      key_in = 4'b0011;
      expect_pulse(1'b1, 4'b0100, cyc + LAT);
      repeat (20) @(negedge clk);
      check("t2_onehot_kept", {28'd0, onehot}, 32'h4);
      release_chk("t2");

      // 3) bounce: two cycles down, one up, then held; re-debounce from the last press
      key_in = 4'b0001;
      repeat (2) @(negedge clk);
      key_in = 4'b0000;
      @(negedge clk);
      key_in = 4'b0001;
      expect_pulse(1'b0, 4'b0001, cyc + LAT);
      repeat (15) @(negedge clk);
      check("t3_onehot", {28'd0, onehot}, 32'h1);
      release_chk("t3");

      // 4) long hold gives a single pulse
      key_in = 4'b1000;
      expect_pulse(1'b0, 4'b1000, cyc + LAT);
      repeat (50) @(negedge clk);
      check("t4_onehot", {28'd0, onehot}, 32'h8);
      check("t4_busy_hold", {31'd0, busy}, 32'd1);
      release_chk("t4");

      // 5) reset mid-debounce aborts without a pulse
      key_in = 4'b0010;
      repeat (5) @(negedge clk);
      check("t5_busy_debounce", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("t5_rst_onehot", {28'd0, onehot}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_valid", {31'd0, key_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      expect_pulse(1'b0, 4'b0010, cyc + LAT);
      repeat (10) @(negedge clk);
      check("t5_onehot", {28'd0, onehot}, 32'h2);
      release_chk("t5");

      // 6) each key in turn, encoder index follows
      seq[0] = 4'b0001;
      seq[1] = 4'b0010;
      seq[2] = 4'b0100;
      seq[3] = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         key_in = seq[i];
         expect_pulse(1'b0, seq[i], cyc + LAT);
         repeat (10) @(negedge clk);
         check("t6_encoder_y", {30'd0, enc(onehot)}, i);
         release_chk("t6");
      end

      repeat (5) @(negedge clk);
      check("missing_pulses", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
